// File: rtl/tcb_dec_pipe.sv
// TCB address decoder: one subordinate port fanned out to BN manager ports with a
// fixed-latency (DLY) response pipeline. Define TCB_DEC_ERR_EN to add the s_err port.
module tcb_dec_pipe #(
  parameter int unsigned           AW  = 32,
  parameter int unsigned           DW  = 32,
  parameter int unsigned           BN  = 2,
  parameter int unsigned           DLY = 1,
  parameter logic [BN-1:0][AW-1:0] AS  = '0,
  parameter logic [BN-1:0][AW-1:0] AM  = '0
)(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_vld,
  input  logic                      s_wen,
  input  logic [DW/8-1:0]           s_ben,
  input  logic [AW-1:0]             s_adr,
  input  logic [DW-1:0]             s_wdt,
  output logic [DW-1:0]             s_rdt,
  output logic                      s_rdy,
`ifdef TCB_DEC_ERR_EN
  output logic                      s_err,
`endif
  output logic [BN-1:0]             m_vld,
  output logic [BN-1:0]             m_wen,
  output logic [BN-1:0][DW/8-1:0]   m_ben,
  output logic [BN-1:0][AW-1:0]     m_adr,
  output logic [BN-1:0][DW-1:0]     m_wdt,
  input  logic [BN-1:0][DW-1:0]     m_rdt,
  input  logic [BN-1:0]             m_rdy
);

  logic [BN-1:0] w_hit;
  logic [BN-1:0] w_sel;
  logic          w_miss;
  logic          w_trn;

  // Lowest-index hit wins when regions overlap.
  always_comb begin
    w_hit  = '0;
    w_sel  = '0;
    w_miss = 1'b1;
    for (int unsigned i = 0; i < BN; i++) begin
      w_hit[i] = (((s_adr ^ AS[i]) & AM[i]) == '0);
      if (w_miss && w_hit[i]) begin
        w_sel[i] = 1'b1;
        w_miss   = 1'b0;
      end
    end
  end

  assign s_rdy = w_miss | (|(w_sel & m_rdy));
  assign w_trn = s_vld & s_rdy;

  always_comb begin
    m_vld = {BN{s_vld}} & w_sel;
    m_wen = {BN{s_wen}};
    m_ben = '0;
    m_adr = '0;
    m_wdt = '0;
    for (int unsigned i = 0; i < BN; i++) begin
      m_ben[i] = s_ben;
      m_adr[i] = s_adr;
      m_wdt[i] = s_wdt;
    end
  end

  logic          w_lvld;
  logic [BN-1:0] w_lsel;
`ifdef TCB_DEC_ERR_EN
  logic          w_lmiss;
`endif

  generate
    if (DLY == 0) begin : g_comb
      assign w_lvld  = w_trn;
      assign w_lsel  = w_sel;
`ifdef TCB_DEC_ERR_EN
      assign w_lmiss = w_miss;
`endif
    end else begin : g_pipe
      logic [DLY-1:0]         r_vld;
      logic [DLY-1:0][BN-1:0] r_sel;
`ifdef TCB_DEC_ERR_EN
      logic [DLY-1:0]         r_miss;
`endif

      // Fixed latency: stages advance every clock, responses are never stalled.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_vld <= '0;
          r_sel <= '0;
`ifdef TCB_DEC_ERR_EN
          r_miss <= '0;
`endif
        end else begin
          r_vld[0] <= w_trn;
          r_sel[0] <= w_sel;
`ifdef TCB_DEC_ERR_EN
          r_miss[0] <= w_miss;
`endif
          for (int unsigned k = 1; k < DLY; k++) begin
            r_vld[k] <= r_vld[k-1];
            r_sel[k] <= r_sel[k-1];
`ifdef TCB_DEC_ERR_EN
            r_miss[k] <= r_miss[k-1];
`endif
          end
        end
      end

      assign w_lvld  = r_vld[DLY-1];
      assign w_lsel  = r_sel[DLY-1];
`ifdef TCB_DEC_ERR_EN
      assign w_lmiss = r_miss[DLY-1];
`endif
    end
  endgenerate

  // A miss carries an all-zero select, so its data slot reads back as zero.
  always_comb begin
    s_rdt = '0;
    for (int unsigned i = 0; i < BN; i++) begin
      if (w_lvld && w_lsel[i]) s_rdt = s_rdt | m_rdt[i];
    end
  end

`ifdef TCB_DEC_ERR_EN
  assign s_err = w_lvld & w_lmiss;
`endif

endmodule

// File: tb/tb_tcb_dec_pipe.sv
// Scoreboard bench for tcb_dec_pipe: three instances (DLY=1 map, DLY=2 map, DLY=0 overlap)
// share one stimulus stream; expected responses are queued at transfer time.
module tb_tcb_dec_pipe;

  localparam logic [31:0] P0 = 32'h1111_A0A0;
  localparam logic [31:0] P1 = 32'h0000_CAFE;
  localparam logic [1:0][31:0] MAP_AS = {32'h0000_1000, 32'h0000_0000};
  localparam logic [1:0][31:0] MAP_AM = {32'h0000_F000, 32'h0000_F000};

  typedef struct {
    int          due;
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_vld = 1'b0;
  logic             s_wen = 1'b0;
  logic [3:0]       s_ben = 4'hF;
  logic [31:0]      s_adr = '0;
  logic [31:0]      s_wdt = 32'h5A5A_0000;
  logic [1:0][31:0] m_rdt = {P1, P0};
  logic [1:0]       m_rdy = 2'b11;

  logic [31:0]      rdt1, rdt2, rdt3;
  logic             rdy1, rdy2, rdy3;
  logic [1:0]       vld1, vld2, vld3;
  logic [1:0]       wen1, wen2, wen3;
  logic [1:0][3:0]  ben1, ben2, ben3;
  logic [1:0][31:0] adr1, adr2, adr3;
  logic [1:0][31:0] wdt1, wdt2, wdt3;
`ifdef TCB_DEC_ERR_EN
  logic             err1, err2, err3;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  rsp_t q1[$], q2[$], q3[$];

  always #5 clk = ~clk;

  tcb_dec_pipe #(.AW(32), .DW(32), .BN(2), .DLY(1), .AS(MAP_AS), .AM(MAP_AM)) dut1 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr),
    .s_wdt(s_wdt), .s_rdt(rdt1), .s_rdy(rdy1),
`ifdef TCB_DEC_ERR_EN
    .s_err(err1),
`endif
    .m_vld(vld1), .m_wen(wen1), .m_ben(ben1), .m_adr(adr1), .m_wdt(wdt1),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  tcb_dec_pipe #(.AW(32), .DW(32), .BN(2), .DLY(2), .AS(MAP_AS), .AM(MAP_AM)) dut2 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr),
    .s_wdt(s_wdt), .s_rdt(rdt2), .s_rdy(rdy2),
`ifdef TCB_DEC_ERR_EN
    .s_err(err2),
`endif
    .m_vld(vld2), .m_wen(wen2), .m_ben(ben2), .m_adr(adr2), .m_wdt(wdt2),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  tcb_dec_pipe #(.AW(32), .DW(32), .BN(2), .DLY(0), .AS('0), .AM('0)) dut3 (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_wen(s_wen), .s_ben(s_ben), .s_adr(s_adr),
    .s_wdt(s_wdt), .s_rdt(rdt3), .s_rdy(rdy3),
`ifdef TCB_DEC_ERR_EN
    .s_err(err3),
`endif
    .m_vld(vld3), .m_wen(wen3), .m_ben(ben3), .m_adr(adr3), .m_wdt(wdt3),
    .m_rdt(m_rdt), .m_rdy(m_rdy));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Pop the response due this cycle (if any) and compare; otherwise expect idle outputs.
  task automatic chk_rsp(input string tag, inout rsp_t q[$], input logic [31:0] rdt,
                         input logic err);
    logic [31:0] e_dat;
    logic        e_err;
    e_dat = '0;
    e_err = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e_dat = q[0].dat;
      e_err = q[0].err;
      void'(q.pop_front());
    end
    chk({tag, "_rdt"}, rdt, e_dat);
`ifdef TCB_DEC_ERR_EN
    chk({tag, "_err"}, {31'd0, err}, {31'd0, e_err});
`else
    if (err !== 1'b0) chk({tag, "_err"}, {31'd0, err}, 32'd0);
`endif
  endtask

  task automatic check_cycle();
    logic        miss;
    logic        port;
    logic [1:0]  e_vld;
    logic        e_rdy;
    logic [31:0] e_dat;
    rsp_t        r;
    logic        e1, e2, e3;
    miss  = !(s_adr[15:12] == 4'h0 || s_adr[15:12] == 4'h1);
    port  = (s_adr[15:12] == 4'h1);
    e_vld = (s_vld && !miss) ? (port ? 2'b10 : 2'b01) : 2'b00;
    e_rdy = miss ? 1'b1 : m_rdy[port];
    e_dat = miss ? 32'd0 : (port ? P1 : P0);

    chk("map1_mvld", {30'd0, vld1}, {30'd0, e_vld});
    chk("map1_srdy", {31'd0, rdy1}, {31'd0, e_rdy});
    chk("map2_mvld", {30'd0, vld2}, {30'd0, e_vld});
    chk("map2_srdy", {31'd0, rdy2}, {31'd0, e_rdy});
    chk("ovl_mvld",  {30'd0, vld3}, {30'd0, s_vld ? 2'b01 : 2'b00});
    chk("ovl_srdy",  {31'd0, rdy3}, {31'd0, m_rdy[0]});
    chk("bcast_adr", adr1[1], s_adr);
    chk("bcast_wdt", wdt2[0], s_wdt);

    if (!rst && s_vld && e_rdy) begin
      r.dat = e_dat; r.err = miss;
      r.due = cyc + 1; q1.push_back(r);
      r.due = cyc + 2; q2.push_back(r);
    end
    if (!rst && s_vld && m_rdy[0]) begin
      r.dat = P0; r.err = 1'b0; r.due = cyc;
      q3.push_back(r);
    end

`ifdef TCB_DEC_ERR_EN
    e1 = err1; e2 = err2; e3 = err3;
`else
    e1 = 1'b0; e2 = 1'b0; e3 = 1'b0;
`endif
    chk_rsp("map1", q1, rdt1, e1);
    chk_rsp("map2", q2, rdt2, e2);
    chk_rsp("ovl",  q3, rdt3, e3);

    // Reset at the coming edge flushes everything still in flight.
    if (rst) begin
      q1.delete();
      q2.delete();
      q3.delete();
    end
  endtask

  task automatic step(input logic vld, input logic wen, input logic [31:0] adr,
                      input logic [1:0] rdy, input logic rs);
    @(posedge clk);
    #1;
    s_vld = vld;
    s_wen = wen;
    s_adr = adr;
    m_rdy = rdy;
    rst   = rs;
    s_wdt = s_wdt + 32'd1;
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  initial begin
    logic [31:0] a;
    step(0, 0, 32'h0, 2'b11, 1);
    step(0, 0, 32'h0, 2'b11, 1);
    step(0, 0, 32'h0, 2'b11, 0);
    // single read to port 1
    step(1, 0, 32'h0000_1004, 2'b11, 0);
    step(0, 0, 32'h0, 2'b11, 0);
    step(0, 0, 32'h0, 2'b11, 0);
    // back-to-back alternating ports
    step(1, 0, 32'h0000_0000, 2'b11, 0);
    step(1, 0, 32'h0000_1000, 2'b11, 0);
    step(1, 0, 32'h0000_0000, 2'b11, 0);
    step(0, 0, 32'h0, 2'b11, 0);
    step(0, 0, 32'h0, 2'b11, 0);
    // port 0 stalls for three cycles
    step(1, 0, 32'h0000_0008, 2'b10, 0);
    step(1, 0, 32'h0000_0008, 2'b10, 0);
    step(1, 0, 32'h0000_0008, 2'b10, 0);
    step(1, 0, 32'h0000_0008, 2'b11, 0);
    repeat (3) step(0, 0, 32'h0, 2'b11, 0);
    // unmapped address
    step(1, 0, 32'h0000_8000, 2'b00, 0);
    repeat (3) step(0, 0, 32'h0, 2'b11, 0);
    // write travels the pipeline like a read
    step(1, 1, 32'h0000_1010, 2'b11, 0);
    repeat (3) step(0, 0, 32'h0, 2'b11, 0);
    // reset one cycle after a transfer
    step(1, 0, 32'h0000_0004, 2'b11, 0);
    step(0, 0, 32'h0, 2'b11, 1);
    repeat (3) step(0, 0, 32'h0, 2'b11, 0);
    // mixed traffic
    for (int i = 0; i < 40; i++) begin
      a = {16'h0, 4'(($urandom_range(0, 2) == 2) ? 8 : $urandom_range(0, 1)),
           12'($urandom_range(0, 4095))};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
           2'($urandom_range(0, 3)), 0);
    end
    repeat (4) step(0, 0, 32'h0, 2'b11, 0);
    if (q1.size() != 0 || q2.size() != 0 || q3.size() != 0)
      chk("drain", 32'(q1.size() + q2.size() + q3.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
